// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
package sync_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 2;

  typedef logic [ADDR_WIDTH_DEF:0] count_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake, data and status bundle between a FIFO and its producer/consumer.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) ();
  logic                  write_req;
  logic                  read_req;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  write_req, read_req, clr_err, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport master (
    output write_req, read_req, clr_err, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read address.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 2,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input logic               clk,
  input logic               reset,
  sync_fifo_flags_if.slave  bus
);
  localparam int                  DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam int                  CW      = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_af_chk
    $error("sync_fifo_flags: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_ae_chk
    $error("sync_fifo_flags: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] rd_data;
  status_t               status;
  logic                  read_acc;
  logic                  write_acc;

  // Flags decode straight from the registered count
  always_comb begin
    status              = '0;
    status.full         = (count == DEPTH_C);
    status.empty        = (count == '0);
    status.almost_full  = (count >= AF_C);
    status.almost_empty = (count <= AE_C);
  end

  // A read on a full FIFO frees the slot the simultaneous write needs
  assign read_acc  = bus.read_req && !status.empty;
  assign write_acc = bus.write_req && (!status.full || read_acc);

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (write_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (read_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({write_acc, read_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh error outranks a clear in the same cycle
      if (bus.write_req && !write_acc) overflow <= 1'b1;
      else if (bus.clr_err)            overflow <= 1'b0;
      if (bus.read_req && !read_acc)   underflow <= 1'b1;
      else if (bus.clr_err)            underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = status.empty ? '0 : rd_data;
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        data_out_q <= '0;
    else if (read_acc) data_out_q <= rd_data;
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (DEPTH=4, default thresholds).
module tb_sync_fifo_flags;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  sync_fifo_flags #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (2),
    .AFULL_THRESH  (3),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bus.write_req = w;
    bus.read_req  = r;
    bus.data_in   = d;
    @(posedge clk);
    #1;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    bus.clr_err   = 1'b0;
  endtask

  // Returns the word delivered by a single pop, in either read mode
  task automatic pop(output logic [7:0] obs);
`ifdef FIFO_FWFT_EN
    obs = bus.data_out;
    step(1'b0, 1'b1, 8'h00);
`else
    step(1'b0, 1'b1, 8'h00);
    obs = bus.data_out;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", bus.almost_empty); end
    total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
    total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {bus.overflow, bus.underflow}); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain;
    logic [7:0] vals [4];
    logic [7:0] obs;
    vals = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, vals[i]);
      total++; if (bus.count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i + 1); end
      total++; if (bus.almost_full !== (i >= 2)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, bus.almost_full, i >= 2); end
      total++; if (bus.full !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.full, i == 3); end
      total++; if (bus.almost_empty !== (i == 0)) begin bad++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, bus.almost_empty, i == 0); end
    end
    for (int i = 0; i < 4; i++) begin
      pop(obs);
      total++; if (obs !== vals[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, obs, vals[i]); end
      total++; if (bus.count !== 3'(3 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.count, 3 - i); end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL drain_underflow got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_overflow;
    logic [7:0] obs;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(i + 1));
    step(1'b1, 1'b0, 8'h11);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", bus.count); end
    bus.clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      pop(obs);
      total++; if (obs !== 8'(i + 1)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, obs, 8'(i + 1)); end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_underflow;
    logic [7:0] obs;
    logic [7:0] exp_hold;
`ifdef FIFO_FWFT_EN
    exp_hold = 8'h00;
`else
    exp_hold = 8'h04;
`endif
    step(1'b0, 1'b1, 8'h00);
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", bus.underflow); end
    total++; if (bus.data_out !== exp_hold) begin bad++; $display("FAIL udf_hold got=%h exp=%h", bus.data_out, exp_hold); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", bus.count); end
    bus.clr_err = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL udf_err_wins got=%b exp=1", bus.underflow); end
    bus.clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", bus.underflow); end
    step(1'b1, 1'b1, 8'h22);
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL wr_rd_empty_count got=%0d exp=1", bus.count); end
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL wr_rd_empty_udf got=%b exp=1", bus.underflow); end
    pop(obs);
    total++; if (obs !== 8'h22) begin bad++; $display("FAIL wr_rd_empty_data got=%h exp=22", obs); end
    bus.clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_full_rw;
    logic [7:0] obs;
    logic [7:0] pre;
    logic [7:0] exp_tail [4];
    exp_tail = '{8'h32, 8'h33, 8'h34, 8'hCC};
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h31 + i));
    pre = bus.data_out;
    step(1'b1, 1'b1, 8'hCC);
`ifdef FIFO_FWFT_EN
    obs = pre;
`else
    obs = bus.data_out;
`endif
    total++; if (obs !== 8'h31) begin bad++; $display("FAIL full_rw_data got=%h exp=31", obs); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_rw_count got=%0d exp=4", bus.count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_rw_ovf got=%b exp=0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      pop(obs);
      total++; if (obs !== exp_tail[i]) begin bad++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, obs, exp_tail[i]); end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b0, 8'h3C);
    bus.write_req = 1'b1;
    bus.data_in   = 8'h4D;
    @(posedge clk);
    #2;
    bus.write_req = 1'b0;
    total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL arst_pre_count got=%0d exp=2", bus.count); end
    reset = 1'b0;
    #1;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b exp=1", bus.empty); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL arst_dout got=%h exp=00", bus.data_out); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 8'h00);
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL arst_udf got=%b exp=1", bus.underflow); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL arst_post_count got=%0d exp=0", bus.count); end
    bus.clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft;
    step(1'b1, 1'b0, 8'h77);
    total++; if (bus.data_out !== 8'h77) begin bad++; $display("FAIL fwft_show got=%h exp=77", bus.data_out); end
    step(1'b0, 1'b1, 8'h00);
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL fwft_pop got=%h exp=00", bus.data_out); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fwft_empty got=%b exp=1", bus.empty); end
  endtask
`endif

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    bus.clr_err   = 1'b0;
    bus.data_in   = 8'h00;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_async_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
